// File: rtl/alu_result_fifo.sv
// Captures ALU results plus op code, derives status flags at write, buffers them in a FWFT FIFO.
// Head visible 1 cycle after a push into empty; in_ready drops when full and the producer holds.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par,
  output logic             out_badop,
  output logic [AW:0]      count
);

  typedef struct packed {
    logic             badop;
    logic             par;
    logic             neg;
    logic             zero;
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        wr_ent;
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags are frozen at capture so the consumer never recomputes them.
  always_comb begin
    wr_ent       = '0;
    wr_ent.data  = in_data;
    wr_ent.op    = in_op;
    wr_ent.zero  = (in_data == '0);
    wr_ent.neg   = in_data[WIDTH-1];
    wr_ent.par   = ^in_data;
    wr_ent.badop = in_op[2] & (in_op[1] | in_op[0]);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is uninitialised after reset, so the head is masked while empty.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head.data;
  assign out_op    = head.op;
  assign out_zero  = head.zero;
  assign out_neg   = head.neg;
  assign out_par   = head.par;
  assign out_badop = head.badop;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: queue-based reference model, directed scenarios, random traffic.
module tb_alu_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic       badop;
    logic       par;
    logic       neg;
    logic       zero;
    logic [2:0] op;
    logic [3:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [2:0]       in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op;
  logic             out_zero, out_neg, out_par, out_badop;
  logic [AW:0]      count;

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  int   occ    = 0;
  ent_t exp_q[$];

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_par(out_par), .out_badop(out_badop),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [2:0] op, input logic [3:0] d);
    ent_t e;
    int   v;
    v       = int'(d);
    e.data  = d;
    e.op    = op;
    e.zero  = (v == 0);
    e.neg   = (v >= 8);
    e.par   = ($countones(d) % 2) == 1;
    e.badop = (int'(op) >= 5);
    return e;
  endfunction

  function automatic ent_t dut_head();
    ent_t e;
    e = {out_badop, out_par, out_neg, out_zero, out_op, out_data};
    return e;
  endfunction

  // Input side of the model: occupancy snapshot, then accept if there was room.
  always @(negedge clk) begin
    if (!rst) begin
      occ = exp_q.size();
      chk("count", 32'(count), 32'(occ));
      chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
      if (in_valid && occ < DEPTH) exp_q.push_back(model(in_op, in_data));
    end
  end

  // Output monitor: head must match the oldest model entry every valid cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      if (occ > 0) begin
        chk("head", 32'(dut_head()), 32'(exp_q[0]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end else begin
        chk("empty_head", 32'(dut_head()), 32'(0));
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic [2:0] o, input logic r);
    in_valid  = v;
    in_data   = d;
    in_op     = o;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 4'h0, 3'd0, 1'b1);
    chk("drained_count", 32'(count), 32'(0));
  endtask

  initial begin
    int pops0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    rst = 1'b0;

    // Asynchronous reset with two entries buffered.
    step(1'b1, 4'h9, 3'd2, 1'b0);
    step(1'b1, 4'h6, 3'd1, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'(2));
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'(0));
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_out_data", 32'(out_data), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Flag derivation and ordering.
    step(1'b1, 4'h0, 3'd1, 1'b0);
    step(1'b1, 4'hA, 3'd3, 1'b0);
    step(1'b1, 4'h7, 3'd4, 1'b0);
    step(1'b0, 4'h0, 3'd0, 1'b0);
    chk("three_count", 32'(count), 32'(3));
    chk("h0_zero", 32'(out_zero), 32'(1));
    chk("h0_par", 32'(out_par), 32'(0));
    step(1'b0, 4'h0, 3'd0, 1'b1);
    chk("h1_data", 32'(out_data), 32'(4'hA));
    chk("h1_neg", 32'(out_neg), 32'(1));
    chk("h1_par", 32'(out_par), 32'(0));
    chk("h1_op", 32'(out_op), 32'(3));
    step(1'b0, 4'h0, 3'd0, 1'b1);
    chk("h2_data", 32'(out_data), 32'(4'h7));
    chk("h2_par", 32'(out_par), 32'(1));
    drain();

    // Fill, hold a fifth push against backpressure, then release one slot.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i + 1), 3'(i), 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_count", 32'(count), 32'(4));
    for (int i = 0; i < 3; i++) step(1'b1, 4'hE, 3'd2, 1'b0);
    chk("held_count", 32'(count), 32'(4));
    step(1'b1, 4'hE, 3'd2, 1'b1);
    chk("pop_from_full", 32'(count), 32'(3));
    chk("ready_after_pop", 32'(in_ready), 32'(1));
    step(1'b1, 4'hE, 3'd2, 1'b0);
    chk("held_stored", 32'(count), 32'(4));

    // Continuous push/pop from full: pointers wrap repeatedly.
    pops0 = pops;
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 3'(i % 5), 1'b1);
    chk("stream_pops", 32'(pops - pops0), 32'(20));
    drain();

    // Push and pop together while empty: only the push happens.
    step(1'b1, 4'h3, 3'd2, 1'b1);
    chk("empty_pp_count", 32'(count), 32'(1));
    chk("empty_pp_valid", 32'(out_valid), 32'(1));
    drain();

    // Undefined select codes.
    step(1'b1, 4'h1, 3'd5, 1'b0);
    step(1'b1, 4'h2, 3'd6, 1'b0);
    step(1'b1, 4'h3, 3'd7, 1'b0);
    step(1'b1, 4'h4, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("badop_op", 32'(out_op), 32'((i < 3) ? 5 + i : 4));
      chk("badop_flag", 32'(out_badop), 32'(i < 3));
      step(1'b0, 4'h0, 3'd0, 1'b1);
    end

    // Random traffic; producer holds its word while stalled.
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [3:0] d;
      logic [2:0] o;
      if (in_valid && !in_ready) begin
        v = 1'b1; d = in_data; o = in_op;
      end else begin
        v = ($urandom_range(99) < 60);
        d = 4'($urandom_range(15));
        o = 3'($urandom_range(7));
      end
      step(v, d, o, ($urandom_range(99) < 50));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
